reservation_stations: RTL

Reservation-station array that sits directly upstream of the issue stage. It accepts decoded instructions from dispatch into the lowest free slot and captures operand values broadcast on the common data bus (CDB). It frees the slot the issue stage selected and exports the whole array to issue every cycle. Issue reads the array combinationally; this block owns all entry state.

---
 rtl/reservation_stations_pkg.sv | 37 +++
 rtl/reservation_stations_if.sv | 30 +++
 rtl/reservation_stations_rs_alloc.sv | 22 ++
 rtl/reservation_stations.sv | 103 ++++++++++
 4 files changed

// File: rtl/reservation_stations_pkg.sv
// Shared reservation-station types, sizes and tag constants, also imported by the issue stage.
// RS_SIZE may be overridden with `define RS_SIZE before this file is compiled.
`ifndef RS_SIZE
`define RS_SIZE 8
`endif

package reservation_stations_pkg;

  localparam int DATA_W  = 32;
  localparam int TAG_W   = 32;
  localparam int RS_SIZE = `RS_SIZE;

  typedef logic [DATA_W-1:0] MemoryWord;
  typedef logic [TAG_W-1:0]  rob_tag_t;

  localparam rob_tag_t TAG_NONE = '0;

  typedef struct packed {
    logic [3:0] alu_op;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
  } control_bits;

  typedef struct packed {
    logic        busy;
    logic [31:0] id;
    rob_tag_t    tag;
    rob_tag_t    tag_1;
    rob_tag_t    tag_2;
    MemoryWord   value_1;
    MemoryWord   value_2;
    MemoryWord   imm;
    control_bits ctrl_bits;
  } rs_entry;

endpackage

// File: rtl/reservation_stations_if.sv
// Dispatch / issue / CDB bundle between the pipeline and the reservation stations.
interface reservation_stations_if;
  import reservation_stations_pkg::*;

  logic      dispatch_valid;
  rs_entry   dispatch_entry;
  logic      dispatch_ready;
  logic      issue_valid;
  int        issue_rs_id;
  logic      cdb_valid;
  rob_tag_t  cdb_tag;
  MemoryWord cdb_value;
  rs_entry   res_stations [RS_SIZE];
  int        count;
  logic      full;
  logic      empty;

  modport master (
    output dispatch_valid, dispatch_entry, issue_valid, issue_rs_id,
           cdb_valid, cdb_tag, cdb_value,
    input  dispatch_ready, res_stations, count, full, empty
  );

  modport slave (
    input  dispatch_valid, dispatch_entry, issue_valid, issue_rs_id,
           cdb_valid, cdb_tag, cdb_value,
    output dispatch_ready, res_stations, count, full, empty
  );

endinterface

// File: rtl/reservation_stations_rs_alloc.sv
// Priority encoder: lowest set bit of free_mask plus a found flag.
module rs_alloc #(
  parameter int N = 8,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] free_mask,
  output logic [W-1:0] idx,
  output logic         found
);

  always_comb begin
    idx   = '0;
    found = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        idx   = W'(i);
        found = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_stations.sv
// Reservation-station array: allocate on dispatch, wake on CDB, free on issue.
// Optional macro RS_BYPASS_EN: dispatch operands matching the concurrent CDB are captured.
module reservation_stations
  import reservation_stations_pkg::*;
(
  input logic                 clk,
  input logic                 reset,
  reservation_stations_if.slave bus
);

  localparam int             IDX_W    = $clog2(RS_SIZE);
  localparam logic [IDX_W:0] FULL_CNT = (IDX_W + 1)'(RS_SIZE);

  rs_entry          entries_q [RS_SIZE];
  rs_entry          entries_d [RS_SIZE];
  logic [IDX_W:0]   count_q, count_d;
  logic [RS_SIZE-1:0] free_mask;
  logic [IDX_W-1:0] alloc_idx;
  logic             alloc_found;
  logic [IDX_W-1:0] issue_idx;
  logic             issue_in_range;
  logic             full, accept, valid_free, wake;
  rs_entry          new_entry;

  always_comb begin
    free_mask = '0;
    for (int i = 0; i < RS_SIZE; i++) free_mask[i] = !entries_q[i].busy;
  end

  rs_alloc #(.N(RS_SIZE), .W(IDX_W)) u_alloc (
    .free_mask (free_mask),
    .idx       (alloc_idx),
    .found     (alloc_found)
  );

  always_comb begin
    full           = (count_q == FULL_CNT);
    issue_in_range = (bus.issue_rs_id >= 0) && (bus.issue_rs_id < RS_SIZE);
    issue_idx      = bus.issue_rs_id[IDX_W-1:0];
    valid_free     = bus.issue_valid && issue_in_range && entries_q[issue_idx].busy;
    accept         = bus.dispatch_valid && !full && alloc_found;
    wake           = bus.cdb_valid && (bus.cdb_tag != TAG_NONE);
  end

  always_comb begin
    new_entry      = bus.dispatch_entry;
    new_entry.busy = 1'b1;
`ifdef RS_BYPASS_EN
    if (wake && new_entry.tag_1 == bus.cdb_tag) begin
      new_entry.value_1 = bus.cdb_value;
      new_entry.tag_1   = TAG_NONE;
    end
    if (wake && new_entry.tag_2 == bus.cdb_tag) begin
      new_entry.value_2 = bus.cdb_value;
      new_entry.tag_2   = TAG_NONE;
    end
`endif
  end

  // A dispatch target is never busy and a free target always is, so the two never collide;
  // the free is applied last so it overrides a same-cycle wakeup.
  always_comb begin
    for (int i = 0; i < RS_SIZE; i++) begin
      entries_d[i] = entries_q[i];
      if (entries_q[i].busy && wake) begin
        if (entries_q[i].tag_1 == bus.cdb_tag) begin
          entries_d[i].value_1 = bus.cdb_value;
          entries_d[i].tag_1   = TAG_NONE;
        end
        if (entries_q[i].tag_2 == bus.cdb_tag) begin
          entries_d[i].value_2 = bus.cdb_value;
          entries_d[i].tag_2   = TAG_NONE;
        end
      end
      if (accept && alloc_idx == IDX_W'(i)) begin
        entries_d[i]    = new_entry;
        entries_d[i].id = 32'(i);
      end
      if (valid_free && issue_idx == IDX_W'(i)) entries_d[i].busy = 1'b0;
    end
    count_d = count_q + {{IDX_W{1'b0}}, accept} - {{IDX_W{1'b0}}, valid_free};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        entries_q[i]    <= '0;
        entries_q[i].id <= 32'(i);
      end
      count_q <= '0;
    end else begin
      entries_q <= entries_d;
      count_q   <= count_d;
    end
  end

  assign bus.res_stations   = entries_q;
  assign bus.count          = 32'(count_q);
  assign bus.full           = full;
  assign bus.empty          = (count_q == '0);
  assign bus.dispatch_ready = !full;

endmodule
